pixel_collector: RTL and testbench
==================================

Name: pixel_collector

Overview:
Parametrised successor to the 4-core pixel buffer. It merges pixels from NUM_CORES ray-tracing compute cores into one AXI-Stream-style RGB stream for the video packer. Strict round-robin pixel order is enforced over a runtime-selectable number of active cores. Each core has its own small FIFO, so cores are not serialised behind the packer. Start-of-frame and end-of-line sideband signals are generated.

Parameters:
NUM_CORES, 4, number of compute-core input channels (1..16)
PIX_W, 24, pixel width, packed {r,g,b}, 8 bits per channel
FIFO_DEPTH, 4, entries per core FIFO (power of two, >=2)
H_RES, 640, pixels per line
V_RES, 480, lines per frame
TIMEOUT_CYCLES, 1024, watchdog threshold (used only with the optional feature)

Ports:
aclk  in  1  clock
aresetn  in  1  asynchronous active-low reset
active_cores  in  $clog2(NUM_CORES)+1  number of cores in use; 0 is treated as 1, values >NUM_CORES are clamped to NUM_CORES
in_pixel  in  NUM_CORES*PIX_W  per-core pixel; core i occupies bits [i*PIX_W +: PIX_W]
in_valid  in  NUM_CORES  per-core pixel valid
in_ready  out  NUM_CORES  per-core ready (FIFO not full and core active)
out_pixel  out  PIX_W  head pixel of the selected core
out_valid  out  1  output valid
out_ready  in  1  downstream ready
out_user  out  1  start of frame (x==0, y==0), qualified by out_valid
out_last  out  1  end of line (x==H_RES-1), qualified by out_valid
frame_done  out  1  one-cycle pulse after the last pixel of a frame is accepted

Behaviour:
- Reset values: in_ready=0, out_valid=0, out_pixel=0, out_user=0, out_last=0, frame_done=0. All FIFOs are empty; ptr=0, x=0, y=0; state=IDLE; the latched active count is 1.
- FIFO push: core i is written when in_valid[i] && in_ready[i]. in_ready[i] = !full[i] && (i < act), where act is the latched count. There is no write-through when full, even if a pop happens in the same cycle.
- FIFO pop: only FIFO[ptr] is popped, when out_valid && out_ready.
- Output: out_pixel is the head of FIFO[ptr]; out_valid = (state==STREAM) && !empty[ptr].
- Latency: a pixel pushed at edge t is visible at the output after edge t; there is no empty-FIFO bypass.
- While out_valid && !out_ready, out_pixel, out_user and out_last hold stable.
- Order: output pixel k always comes from core (k mod act). ptr increments per transfer and wraps from act-1 to 0. An empty head FIFO stalls the output; other cores keep filling until their FIFOs are full.
- Counters: x increments per transfer and wraps at H_RES-1, which increments y. y wraps at V_RES-1 and triggers END_FRAME.
- FSM, IDLE: latch act from active_cores (clamped), ptr=0; next state STREAM.
- FSM, STREAM: transfer pixels. On the transfer with x==H_RES-1 and y==V_RES-1, go to END_FRAME.
- FSM, END_FRAME (1 cycle): frame_done=1, out_valid=0, x=y=0, ptr=0. Go to IDLE if all FIFOs are empty, else STREAM with act unchanged.
- act changes only in IDLE, so mid-frame changes to active_cores are ignored.
- Pushes stay enabled in every state.
- Reset asserted mid-frame: all FIFOs are discarded immediately, outputs return to reset values, and the first pixel after release is treated as frame start.

Optional Feature:
PIXEL_COLLECTOR_TIMEOUT_EN:
- Defined: a counter runs while state==STREAM && empty[ptr]. When it reaches TIMEOUT_CYCLES, the block emits a fill pixel 0 for core ptr (out_valid=1, FIFO not popped), advances ptr, x and y normally, and sets a sticky 1-bit output port err_timeout (cleared only by reset).
- Defined: the counter clears on any transfer.
- Not defined: no counter, no err_timeout port, and an empty head FIFO stalls indefinitely.

Test Plan:
- NUM_CORES=4, active_cores=4, each core pushes 4 pixels with value (core<<16 | seq), out_ready=1 -> output order c0s0,c1s0,c2s0,c3s0,c0s1,...; first out_valid one cycle after the first push.
- active_cores=2 -> in_ready[3:2] stays 0; output alternates only between c0 and c1.
- H_RES=4, V_RES=2, 8 pixels -> out_user on pixel 0 only; out_last on pixels 3 and 7; frame_done pulses once, one cycle after pixel 7.
- out_ready=0 for 10 cycles with all cores pushing -> each in_ready drops after FIFO_DEPTH=4 pushes; out_pixel stays stable; no pixel lost or duplicated after release.
- Core 1 silent, others pushing -> output stalls after c0s0; with PIXEL_COLLECTOR_TIMEOUT_EN and TIMEOUT_CYCLES=16, a fill pixel 0 appears 16 cycles later, err_timeout=1, and c2 follows.
- aresetn pulsed low mid-frame with FIFOs partly full -> all outputs 0 at once; next accepted pixel carries out_user=1.

Source files
------------

// File: rtl/pixel_collector.sv
// pixel_collector: round-robin merge of NUM_CORES per-core pixel FIFOs into one RGB stream with SOF/EOL sideband.
// Define PIXEL_COLLECTOR_TIMEOUT_EN to add the empty-head watchdog, fill pixels and the err_timeout port.
module pixel_collector #(
    parameter int NUM_CORES      = 4,
    parameter int PIX_W          = 24,
    parameter int FIFO_DEPTH     = 4,
    parameter int H_RES          = 640,
    parameter int V_RES          = 480,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                          aclk,
    input  logic                          aresetn,
    input  logic [$clog2(NUM_CORES):0]    active_cores,
    input  logic [NUM_CORES*PIX_W-1:0]    in_pixel,
    input  logic [NUM_CORES-1:0]          in_valid,
    output logic [NUM_CORES-1:0]          in_ready,
    output logic [PIX_W-1:0]              out_pixel,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          out_user,
    output logic                          out_last,
    output logic                          frame_done
`ifdef PIXEL_COLLECTOR_TIMEOUT_EN
    ,output logic                         err_timeout
`endif
);
    localparam int CW = $clog2(NUM_CORES) + 1;
    localparam int PW = NUM_CORES > 1 ? $clog2(NUM_CORES) : 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int XW = H_RES > 1 ? $clog2(H_RES) : 1;
    localparam int YW = V_RES > 1 ? $clog2(V_RES) : 1;

    typedef enum logic [1:0] {IDLE, STREAM, END_FRAME} state_t;

    state_t               state_q, state_d;
    logic [PW-1:0]        ptr, last, last_c;
    logic [CW-1:0]        act_c;
    logic [XW-1:0]        x;
    logic [YW-1:0]        y;
    logic                 rdy_en, fill, xfer, pop_sel, x_end, y_end;
    logic [NUM_CORES-1:0] full, empty, push, pop;
    logic [PIX_W-1:0]     head [NUM_CORES];

    for (genvar i = 0; i < NUM_CORES; i++) begin : g_core
        logic [PIX_W-1:0] mem [FIFO_DEPTH];
        logic [AW:0]      wp, rp;
        assign full[i]     = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
        assign empty[i]    = wp == rp;
        assign in_ready[i] = rdy_en && !full[i] && (PW'(i) <= last);
        assign push[i]     = in_valid[i] && in_ready[i];
        assign pop[i]      = pop_sel && (ptr == PW'(i));
        assign head[i]     = mem[rp[AW-1:0]];
        always_ff @(posedge aclk)
            if (push[i]) mem[wp[AW-1:0]] <= in_pixel[i*PIX_W +: PIX_W];
        always_ff @(posedge aclk or negedge aresetn)
            if (!aresetn) begin
                wp <= '0;
                rp <= '0;
            end else begin
                if (push[i]) wp <= wp + 1'b1;
                if (pop[i]) rp <= rp + 1'b1;
            end
    end

`ifdef PIXEL_COLLECTOR_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tcnt;
    // A fill pixel is held on the output until accepted; the counter restarts after it.
    assign fill = (state_q == STREAM) && empty[ptr] && (tcnt == TW'(TIMEOUT_CYCLES));
    always_ff @(posedge aclk or negedge aresetn)
        if (!aresetn) begin
            tcnt        <= '0;
            err_timeout <= 1'b0;
        end else begin
            if (xfer || state_q != STREAM || !empty[ptr]) tcnt <= '0;
            else if (!fill) tcnt <= tcnt + 1'b1;
            if (fill) err_timeout <= 1'b1;
        end
`else
    assign fill = 1'b0;
`endif

    assign out_valid  = (state_q == STREAM) && (!empty[ptr] || fill);
    assign xfer       = out_valid && out_ready;
    assign pop_sel    = xfer && !empty[ptr];
    assign out_pixel  = (out_valid && !empty[ptr]) ? head[ptr] : '0;
    assign x_end      = x == XW'(H_RES - 1);
    assign y_end      = y == YW'(V_RES - 1);
    assign out_user   = out_valid && (x == '0) && (y == '0);
    assign out_last   = out_valid && x_end;
    assign frame_done = state_q == END_FRAME;

    always_comb begin
        act_c   = (active_cores == '0) ? CW'(1) :
                  (active_cores > CW'(NUM_CORES)) ? CW'(NUM_CORES) : active_cores;
        last_c  = PW'(act_c - CW'(1));
        state_d = (state_q == IDLE)      ? STREAM :
                  (state_q == END_FRAME) ? (&empty ? IDLE : STREAM) :
                  (xfer && x_end && y_end) ? END_FRAME : STREAM;
    end

    // last holds the highest active core index, so a count of 1 resets to 0.
    always_ff @(posedge aclk or negedge aresetn)
        if (!aresetn) begin
            state_q <= IDLE;
            rdy_en  <= 1'b0;
            last    <= '0;
            ptr     <= '0;
            x       <= '0;
            y       <= '0;
        end else begin
            state_q <= state_d;
            rdy_en  <= 1'b1;
            if (state_q == IDLE) begin
                last <= last_c;
                ptr  <= '0;
            end else if (state_q == END_FRAME) begin
                ptr <= '0;
                x   <= '0;
                y   <= '0;
            end else if (xfer) begin
                ptr <= (ptr == last) ? '0 : ptr + 1'b1;
                x   <= x_end ? '0 : x + 1'b1;
                if (x_end) y <= y_end ? '0 : y + 1'b1;
            end
        end
endmodule

// File: tb/tb_pixel_collector.sv
// tb_pixel_collector: directed checks of ordering, sideband, backpressure, stall and async reset.
module tb_pixel_collector;
    localparam int NC = 4;
    localparam int PW = 24;

    logic              aclk = 1'b0;
    logic              aresetn = 1'b0;
    logic [2:0]        active_cores;
    logic [NC*PW-1:0]  in_pixel;
    logic [NC-1:0]     in_valid, in_ready;
    logic [PW-1:0]     out_pixel;
    logic              out_valid, out_ready, out_user, out_last, frame_done;

    always #5 aclk = ~aclk;

    pixel_collector #(
        .NUM_CORES(NC), .PIX_W(PW), .FIFO_DEPTH(4), .H_RES(4), .V_RES(2), .TIMEOUT_CYCLES(16)
    ) dut (
        .aclk(aclk), .aresetn(aresetn), .active_cores(active_cores),
        .in_pixel(in_pixel), .in_valid(in_valid), .in_ready(in_ready),
        .out_pixel(out_pixel), .out_valid(out_valid), .out_ready(out_ready),
        .out_user(out_user), .out_last(out_last), .frame_done(frame_done)
    );

    int            checks, errors, cyc, fd_cnt, stable_err, push0_cyc, fv_cyc;
    int            quota [NC];
    int            sent  [NC];
    logic          ready_ctl, stalled, hold_u, hold_l;
    logic [NC-1:0] hi_seen;
    logic [PW-1:0] hold_pix;
    logic [PW-1:0] lp [$];
    logic          lu [$];
    logic          ll [$];
    int            lc [$];
    int            fdc [$];

    function automatic logic [PW-1:0] pix(input int c, input int s);
        return PW'(((c + 1) << 16) | s);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change only here, so everything sampled here holds until the next rising edge.
    always @(negedge aclk) begin
        cyc++;
        out_ready = ready_ctl;
        for (int c = 0; c < NC; c++) begin
            in_valid[c] = sent[c] < quota[c];
            in_pixel[c*PW +: PW] = pix(c, sent[c]);
        end
        if (aresetn) begin
            hi_seen |= in_ready;
            for (int c = 0; c < NC; c++)
                if (in_valid[c] && in_ready[c]) begin
                    if (c == 0 && sent[0] == 0) push0_cyc = cyc;
                    sent[c]++;
                end
            if (out_valid && fv_cyc < 0) fv_cyc = cyc;
            if (out_valid && out_ready) begin
                lp.push_back(out_pixel);
                lu.push_back(out_user);
                ll.push_back(out_last);
                lc.push_back(cyc);
            end
            if (out_valid && !out_ready) begin
                if (stalled && (out_pixel != hold_pix || out_user != hold_u || out_last != hold_l))
                    stable_err++;
                stalled  = 1'b1;
                hold_pix = out_pixel;
                hold_u   = out_user;
                hold_l   = out_last;
            end else stalled = 1'b0;
            if (frame_done) begin
                fd_cnt++;
                fdc.push_back(cyc);
            end
        end
    end

    task automatic do_reset(input logic [2:0] ac);
        aresetn      = 1'b0;
        active_cores = ac;
        ready_ctl    = 1'b0;
        for (int c = 0; c < NC; c++) begin
            quota[c] = 0;
            sent[c]  = 0;
        end
        lp.delete(); lu.delete(); ll.delete(); lc.delete(); fdc.delete();
        fd_cnt = 0; stable_err = 0; stalled = 1'b0; hi_seen = '0; fv_cyc = -1; push0_cyc = -1;
        @(posedge aclk); #1;
        check("rst_in_ready", 32'(in_ready), 0);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_pixel", 32'(out_pixel), 0);
        check("rst_out_user", 32'(out_user), 0);
        check("rst_out_last", 32'(out_last), 0);
        check("rst_frame_done", 32'(frame_done), 0);
        repeat (2) @(posedge aclk);
        #1 aresetn = 1'b1;
    endtask

    task automatic wait_log(input int n, input int budget);
        for (int i = 0; i < budget && lp.size() < n; i++) @(posedge aclk);
        #1;
        check("log_count", 32'(lp.size()), 32'(n));
    endtask

    initial begin
        ready_ctl = 1'b0;
        hold_pix  = '0; hold_u = 1'b0; hold_l = 1'b0;
        do_reset(3'd4);

        // Four cores, four pixels each, two 8-pixel frames.
        for (int c = 0; c < NC; c++) quota[c] = 4;
        ready_ctl = 1'b1;
        wait_log(16, 100);
        repeat (4) @(posedge aclk);
        #1;
        check("t1_first_valid_latency", 32'(fv_cyc - push0_cyc), 1);
        for (int k = 0; k < 16; k++) begin
            check($sformatf("t1_pix%0d", k), 32'(lp[k]), 32'(pix(k % 4, k / 4)));
            check($sformatf("t1_user%0d", k), 32'(lu[k]), 32'(k % 8 == 0));
            check($sformatf("t1_last%0d", k), 32'(ll[k]), 32'(k % 4 == 3));
        end
        check("t1_frame_count", 32'(fd_cnt), 2);
        check("t1_fd_timing", 32'(fdc[0] - lc[7]), 1);

        // Two active cores: cores 2 and 3 must never be accepted.
        do_reset(3'd2);
        for (int c = 0; c < NC; c++) quota[c] = 4;
        ready_ctl = 1'b1;
        wait_log(8, 100);
        repeat (4) @(posedge aclk);
        #1;
        for (int k = 0; k < 8; k++) begin
            check($sformatf("t2_pix%0d", k), 32'(lp[k]), 32'(pix(k % 2, k / 2)));
            check($sformatf("t2_user%0d", k), 32'(lu[k]), 32'(k == 0));
            check($sformatf("t2_last%0d", k), 32'(ll[k]), 32'(k % 4 == 3));
        end
        check("t2_frame_count", 32'(fd_cnt), 1);
        check("t2_inactive_ready", 32'(hi_seen[3:2]), 0);
        check("t2_sent2", 32'(sent[2]), 0);
        check("t2_sent3", 32'(sent[3]), 0);

        // Backpressure: FIFOs fill to depth, head holds, nothing lost after release.
        do_reset(3'd4);
        for (int c = 0; c < NC; c++) quota[c] = 8;
        repeat (12) @(posedge aclk);
        #1;
        for (int c = 0; c < NC; c++) check($sformatf("t3_sent%0d", c), 32'(sent[c]), 4);
        check("t3_in_ready", 32'(in_ready), 0);
        check("t3_out_valid", 32'(out_valid), 1);
        check("t3_head_pixel", 32'(out_pixel), 32'(pix(0, 0)));
        check("t3_head_user", 32'(out_user), 1);
        check("t3_stable", 32'(stable_err), 0);
        check("t3_no_transfer", 32'(lp.size()), 0);
        ready_ctl = 1'b1;
        wait_log(32, 200);
        for (int k = 0; k < 32; k++) begin
            check($sformatf("t3_pix%0d", k), 32'(lp[k]), 32'(pix(k % 4, k / 4)));
            check($sformatf("t3_last%0d", k), 32'(ll[k]), 32'(k % 4 == 3));
        end

        // Core 1 silent: output stalls after c0s0 while other cores still fill.
        do_reset(3'd4);
        quota[0] = 2; quota[1] = 0; quota[2] = 2; quota[3] = 2;
        ready_ctl = 1'b1;
        repeat (30) @(posedge aclk);
        #1;
        check("t4_count", 32'(lp.size()), 1);
        check("t4_pix0", 32'(lp[0]), 32'(pix(0, 0)));
        check("t4_stalled", 32'(out_valid), 0);
        check("t4_sent2", 32'(sent[2]), 2);
        check("t4_ready0", 32'(in_ready[0]), 1);

        // Asynchronous reset mid-frame with FIFOs partly full.
        @(posedge aclk);
        #1 aresetn = 1'b0;
        #1;
        check("t5_in_ready", 32'(in_ready), 0);
        check("t5_out_valid", 32'(out_valid), 0);
        check("t5_out_pixel", 32'(out_pixel), 0);
        check("t5_out_user", 32'(out_user), 0);
        check("t5_out_last", 32'(out_last), 0);
        do_reset(3'd4);
        for (int c = 0; c < NC; c++) quota[c] = 1;
        ready_ctl = 1'b1;
        wait_log(1, 50);
        check("t5_pix0", 32'(lp[0]), 32'(pix(0, 0)));
        check("t5_user0", 32'(lu[0]), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
